data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// Data SRAM responder: a word-addressed RAM with one-cycle registered reads, plus a small
// config region at 0xBFAF_xxxx holding an LED register and an optional free-running timer.
// Optional feature macro: DATA_SRAM_RESP_TIMER_EN builds the TIMER register at offset 0xE000.
// Without it, offset 0xE000 behaves like any other unmapped config offset.
// LED_W is expected to be in 1..32.
module data_sram_resp #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LED_W  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic [LED_W-1:0] led
);

  localparam int unsigned Words   = 2 ** ADDR_W;
  localparam logic [15:0] CfgBase = 16'hBFAF;
  localparam logic [15:0] LedOff  = 16'hF000;
`ifdef DATA_SRAM_RESP_TIMER_EN
  localparam logic [15:0] TmrOff  = 16'hE000;
`endif

  // Storage and registers
  logic [31:0]      mem_q [Words];
  logic [31:0]      rdata_q, rdata_d;
  logic [LED_W-1:0] led_q, led_d;
`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0]      timer_q, timer_d;
`endif

  // Decode
  logic              is_cfg;
  logic [15:0]       cfg_off;
  logic              led_sel;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       wmask;
  logic [31:0]       led_ext;
  logic [31:0]       led_merged;
  logic [31:0]       cfg_rd;
  logic [31:0]       ram_rd;
`ifdef DATA_SRAM_RESP_TIMER_EN
  logic              tmr_sel;
`endif

  // Byte offset bits never participate in decode
  logic unused_addr;
  assign unused_addr = ^data_sram_addr[1:0];

  assign is_cfg   = (data_sram_addr[31:16] == CfgBase);
  assign cfg_off  = {data_sram_addr[15:2], 2'b00};
  assign led_sel  = is_cfg && (cfg_off == LedOff);
`ifdef DATA_SRAM_RESP_TIMER_EN
  assign tmr_sel  = is_cfg && (cfg_off == TmrOff);
`endif
  // Upper address bits alias onto the RAM
  assign word_idx = data_sram_addr[ADDR_W+1:2];

  assign wmask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                  {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

  // Zero-extend LED to a full word for reads and lane merging
  always_comb begin
    led_ext              = '0;
    led_ext[LED_W-1:0]   = led_q;
  end

  // Lanes above LED_W fall off when truncating back to LED_W bits
  assign led_merged = (led_ext & ~wmask) | (data_sram_wdata & wmask);

  // LED next state: lane-merged write on an enabled access, otherwise hold
  always_comb begin
    led_d = led_q;
    if (data_sram_en && led_sel) begin
      led_d = led_merged[LED_W-1:0];
    end
  end

`ifdef DATA_SRAM_RESP_TIMER_EN
  // Timer next state: a write replaces the increment for that edge
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (data_sram_en && tmr_sel) begin
      timer_d = (timer_q & ~wmask) | (data_sram_wdata & wmask);
    end
  end
`endif

  // Config read mux; unmapped offsets read zero
  always_comb begin
    cfg_rd = '0;
    if (led_sel) begin
      cfg_rd = led_ext;
    end
`ifdef DATA_SRAM_RESP_TIMER_EN
    if (tmr_sel) begin
      cfg_rd = timer_q;
    end
`endif
  end

  assign ram_rd = mem_q[word_idx];

  // Read data captures the pre-edge word on every enabled access, else holds
  always_comb begin
    rdata_d = rdata_q;
    if (data_sram_en) begin
      rdata_d = is_cfg ? cfg_rd : ram_rd;
    end
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (data_sram_en && !is_cfg) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Resettable registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

`ifdef DATA_SRAM_RESP_TIMER_EN
  // Free-running timer register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;

endmodule
